// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
// Holds the receiver FSM encoding, the default bit period and the frame shape
// (8 data bits, 1 stop bit), plus a 2-of-3 majority helper.
package uart_pkg;

   // 27 MHz clock, 115200 baud
   localparam int unsigned DefaultClksPerBit = 234;
   localparam int unsigned NumDataBits       = 8;
   localparam int unsigned NumStopBits       = 1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } rx_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so a reset never looks like a start edge.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   rx      - raw serial input
//   rx_sync - synchronized serial line
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_sync
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= rx;
         sync_q <= meta_q;
      end
   end

   assign rx_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, 1 stop bit, no parity.
// Optional build macro UART_RX_MAJORITY_EN: each bit decision is the 2-of-3
// majority of the line one cycle before, at, and one cycle after the nominal
// sample point, with the decision taken one cycle late.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   rx        - asynchronous serial line, idles high
//   data      - last correctly framed byte
//   valid     - data holds an unread byte
//   ack       - consumer read strobe, clears valid and overrun
//   frame_err - one-cycle pulse when the stop bit samples low
//   overrun   - sticky: a byte completed while valid was high
//   busy      - receiver is not idle
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ack,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam logic [15:0] BitEnd = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [15:0] StartDecide = 16'(CLKS_PER_BIT / 2 + 1);
`else
   localparam logic [15:0] StartDecide = 16'(CLKS_PER_BIT / 2);
`endif
   localparam logic [2:0] LastIdx = 3'(NumDataBits - 1);

   logic rx_s;
   logic rx_prev_q;
   logic sample;

   rx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        ovr_q, ovr_d;
   logic        complete;

   uart_rx_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .rx_sync (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   // Line history: hist_q[0] is one cycle old, hist_q[1] two cycles old.
   logic [1:0] hist_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= {hist_q[0], rx_s};
      end
   end

   assign sample = maj3(hist_q[1], hist_q[0], rx_s);
`else
   assign sample = rx_s;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 16'd1;
      idx_d    = idx_q;
      shift_d  = shift_q;
      complete = 1'b0;
      ferr_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = 16'd0;
            idx_d = 3'd0;
            // Edge, not level: a line held low (break) never starts a frame.
            if (rx_prev_q && !rx_s) begin
               state_d = StStart;
            end
         end
         StStart: begin
            if (cnt_q == StartDecide) begin
               cnt_d   = 16'd0;
               state_d = sample ? StIdle : StData;
            end
         end
         StData: begin
            if (cnt_q == BitEnd) begin
               cnt_d   = 16'd0;
               shift_d = {sample, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == LastIdx) begin
                  state_d = StStop;
               end
            end
         end
         StStop: begin
            if (cnt_q == BitEnd) begin
               cnt_d   = 16'd0;
               state_d = StIdle;
               if (sample) begin
                  complete = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (ack && valid_q) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
      // A completing byte wins over a simultaneous ack; overrun only when
      // the previous byte was left unread.
      if (complete) begin
         data_d  = shift_q;
         valid_d = 1'b1;
         if (valid_q && !ack) begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= 16'd0;
         idx_q     <= 3'd0;
         shift_q   <= 8'h00;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
         rx_prev_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
         rx_prev_q <= rx_s;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   localparam int unsigned Cpb = 16;
`ifdef UART_RX_MAJORITY_EN
   localparam int Lat = 2 + Cpb / 2 + 9 * Cpb + 1 + 1 + 1;
`else
   localparam int Lat = 2 + Cpb / 2 + 9 * Cpb + 1 + 1;
`endif
   // Lat counts edges from the edge after which rx is driven low; the first
   // edge that captures the low pin is edge 1, hence the extra +1.

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ack;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // results of the last run_frame
   int   ev_n;
   int   ferr_cnt;
   logic [7:0] snap_data;
   logic snap_valid, snap_ferr, snap_ovr, snap_busy;

   uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .ack       (ack),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0] b;
      logic       stop;
      logic       ack_first;
      logic [7:0] exp_data;
      logic       exp_valid;
      logic       exp_ferr;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic stop, input int glitch);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < int'(Cpb); c++) begin
            rx = (c == glitch) ? ~bits[k] : bits[k];
            tick();
         end
      end
   endtask

   task automatic run_frame(input logic [7:0] b, input logic stop, input int glitch,
                            input int ack_at, input int rst_at);
      ev_n     = -1;
      ferr_cnt = 0;
      fork
         send(b, stop, glitch);
         begin
            logic pv, po;
            pv = valid;
            po = overrun;
            for (int n = 1; n <= 10 * int'(Cpb); n++) begin
               tick();
               if (frame_err) ferr_cnt++;
               if (ev_n < 0 && (frame_err || (valid && !pv) || (overrun && !po))) ev_n = n;
               pv = valid;
               po = overrun;
               if (n == ack_at - 1) ack = 1'b1;
               if (n == ack_at) ack = 1'b0;
               if (n == rst_at) rst = 1'b1;
               if (n == rst_at + 1) begin
                  snap_data  = data;
                  snap_valid = valid;
                  snap_ferr  = frame_err;
                  snap_ovr   = overrun;
                  snap_busy  = busy;
                  rst        = 1'b0;
               end
            end
         end
      join
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic idle_high(input int n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   initial begin
      logic seen_busy;
      int   bad_busy;

      rst = 1'b1;
      rx  = 1'b1;
      ack = 1'b0;
      repeat (3) tick();
      check("rst_data", data, 8'h00);
      check("rst_valid", valid, 1'b0);
      check("rst_ferr", frame_err, 1'b0);
      check("rst_ovr", overrun, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      idle_high(4);

      vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{8'h55, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1};
      vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};

      for (int i = 0; i < 6; i++) begin
         if (vecs[i].ack_first) begin
            pulse_ack();
            check($sformatf("v%0d_ack_valid", i), valid, 1'b0);
            check($sformatf("v%0d_ack_ovr", i), overrun, 1'b0);
         end
         run_frame(vecs[i].b, vecs[i].stop, -1, 0, 0);
         check($sformatf("v%0d_latency", i), ev_n, Lat);
         check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
         check($sformatf("v%0d_valid", i), valid, vecs[i].exp_valid);
         check($sformatf("v%0d_ferr_pulses", i), ferr_cnt, {31'd0, vecs[i].exp_ferr});
         check($sformatf("v%0d_ovr", i), overrun, vecs[i].exp_ovr);
         idle_high(4);
      end

      // ack coinciding with completion: valid stays, overrun clears
      run_frame(8'h81, 1'b1, -1, Lat, 0);
      check("coinc_data", data, 8'h81);
      check("coinc_valid", valid, 1'b1);
      check("coinc_ovr", overrun, 1'b0);
      idle_high(4);

      // ack while valid is low is ignored; next byte is not an overrun
      pulse_ack();
      pulse_ack();
      run_frame(8'h12, 1'b1, -1, 0, 0);
      check("ign_ack_data", data, 8'h12);
      check("ign_ack_ovr", overrun, 1'b0);
      idle_high(4);
      pulse_ack();

      // 4-cycle glitch is a false start
      seen_busy = 1'b0;
      ferr_cnt  = 0;
      rx = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         if (n == 5) rx = 1'b1;
         tick();
         if (busy) seen_busy = 1'b1;
         if (frame_err) ferr_cnt++;
      end
      check("glitch_busy_seen", seen_busy, 1'b1);
      check("glitch_busy_end", busy, 1'b0);
      check("glitch_valid", valid, 1'b0);
      check("glitch_ferr", ferr_cnt, 0);

      // framing error, then a held-low break must not start a frame
      run_frame(8'h55, 1'b0, -1, 0, 0);
      check("brk_ferr_pulses", ferr_cnt, 1);
      check("brk_data", data, 8'h12);
      check("brk_valid", valid, 1'b0);
      bad_busy = 0;
      ferr_cnt = 0;
      rx = 1'b0;
      for (int n = 0; n < 20 * int'(Cpb); n++) begin
         tick();
         if (busy) bad_busy++;
         if (frame_err) ferr_cnt++;
      end
      check("brk_hold_busy", bad_busy, 0);
      check("brk_hold_ferr", ferr_cnt, 0);
      idle_high(int'(Cpb));
      run_frame(8'h6E, 1'b1, -1, 0, 0);
      check("brk_after_lat", ev_n, Lat);
      check("brk_after_data", data, 8'h6E);
      idle_high(4);

      // reset in the middle of data bit 4 of 0xFF
      run_frame(8'hFF, 1'b1, -1, 0, 5 * int'(Cpb) + 8);
      check("mrst_data", snap_data, 8'h00);
      check("mrst_valid", snap_valid, 1'b0);
      check("mrst_ferr", snap_ferr, 1'b0);
      check("mrst_ovr", snap_ovr, 1'b0);
      check("mrst_busy", snap_busy, 1'b0);
      check("mrst_after_valid", valid, 1'b0);
      check("mrst_after_data", data, 8'h00);
      idle_high(4);
      run_frame(8'h81, 1'b1, -1, 0, 0);
      check("mrst_rx_lat", ev_n, Lat);
      check("mrst_rx_data", data, 8'h81);
      check("mrst_rx_ovr", overrun, 1'b0);
      idle_high(4);

`ifdef UART_RX_MAJORITY_EN
      // one inverted cycle at each bit centre is outvoted
      pulse_ack();
      run_frame(8'h0F, 1'b1, 9, 0, 0);
      check("maj_lat", ev_n, Lat);
      check("maj_data", data, 8'h0F);
      check("maj_valid", valid, 1'b1);
      idle_high(4);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 234, meaning clk cycles per bit (27 MHz, 115200 baud); legal range 8..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port rx, input, 1, asynchronous serial line; idles high.
REQ-005 SHALL have port data, output, 8, last correctly framed byte.
REQ-006 SHALL have port valid, output, 1, high while data holds an unread byte.
REQ-007 SHALL have port ack, input, 1, consumer read strobe; clears valid.
REQ-008 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port overrun, output, 1, sticky flag: a byte completed while valid was high; cleared by ack.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer before any use; all later references to rx mean the synchronized value.
REQ-012 SHALL implement the FSM IDLE -> START -> DATA -> STOP -> IDLE, with a 16-bit bit-period counter and a 3-bit bit index.
REQ-013 In IDLE, a high-to-low transition of rx SHALL enter START with the counter cleared; a level-low rx with no transition SHALL NOT start a frame.
REQ-014 START SHALL sample at count CLKS_PER_BIT/2 (integer division); low -> DATA with the counter cleared; high -> IDLE (false start, no flags).
REQ-015 DATA SHALL sample every CLKS_PER_BIT cycles, shifting LSB first; after the 8th sample it SHALL enter STOP.
REQ-016 STOP SHALL sample after CLKS_PER_BIT cycles; high -> update data and set valid on the next cycle; low -> pulse frame_err for one cycle and leave data and valid unchanged; both cases return to IDLE.
REQ-017 Latency: valid SHALL rise exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the first low rx at the pin (single-sample mode).
REQ-018 ack while valid SHALL clear valid and overrun on the next cycle; ack while valid is low SHALL be ignored.
REQ-019 Completion while valid is high SHALL overwrite data, keep valid high and set overrun; if ack and completion coincide, valid SHALL stay high and overrun SHALL be cleared.
REQ-020 After a frame error, IDLE SHALL require rx high before a new start edge (break condition holds the receiver idle).

Reset
REQ-021 rst SHALL force IDLE, counter 0, index 0, data 8'h00, valid 0, frame_err 0, overrun 0, busy 0, and both synchronizer flops to 1.
REQ-022 rst mid-frame SHALL abandon the frame with no flag or data update; reception resumes on the next start edge after rst falls.

Configuration
REQ-023 Macro UART_RX_MAJORITY_EN: when defined, every sample (start, data, stop) SHALL be the 2-of-3 majority of rx at counts mid-1, mid, mid+1, with the decision taken at mid+1, so valid latency is one cycle longer than REQ-017; when undefined, a single sample at mid SHALL be used.

Structure
REQ-024 Shared package uart_pkg SHALL hold the FSM state encoding, the default CLKS_PER_BIT, and the frame constants (8 data bits, 1 stop bit).
REQ-025 The synchronizer SHALL be the sub-module uart_rx_sync (two flops, reset value 1); everything else stays in uart_rx.

Verification (bench uses CLKS_PER_BIT=16)
REQ-026 Drive frame 0xA5 at 16 cycles/bit -> valid rises per REQ-017, data=8'hA5, frame_err=0; ack -> valid=0 next cycle.
REQ-027 Drive 0x3C then 0xC3 back-to-back without ack -> data=8'hC3, valid=1, overrun=1; ack clears both.
REQ-028 Drive a 4-cycle low glitch on idle rx -> no valid, no frame_err, busy returns low by count 8.
REQ-029 Drive 0x55 with stop bit low -> one-cycle frame_err, data keeps its previous value, valid unchanged; hold rx low 20 bit times -> no new frame until rx goes high and then low.
REQ-030 Assert rst during bit 4 of 0xFF -> all outputs at reset values; a following 0x81 is received correctly.
REQ-031 With UART_RX_MAJORITY_EN defined, invert rx for 1 cycle at the mid-point of every bit of 0x0F -> data=8'h0F and latency +1 cycle.
